sdram_arbiter: RTL

- Shares the single SDRAM controller port between two masters: port 0 (video scan-out, burst reads, high priority) and port 1 (CPU bridge, reads/writes).
- Grants one master a complete SDRAM cycle, from command acceptance to that master's `ack` pulse, and routes commands, response data and `ack` accordingly.
- Uses fixed video priority, with a starvation guard so the CPU always makes progress.
- Sits between the video controller / CPU bridge and the SDRAM controller.

---
 rtl/sdram_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command/response port between two masters:
//   port 0 (video scan-out, burst reads, high priority) and port 1 (CPU
//   bridge, reads and writes). A grant covers one complete SDRAM cycle, from
//   command acceptance up to the owner's ack pulse. Video has fixed priority,
//   but after STARVE_LIMIT consecutive video grants with the CPU waiting, the
//   CPU is granted next.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   m0_*                          video master: request, address, read data, ack
//   m1_*                          CPU master: request, address, wr/wdata, response, ack
//   sdram_rdy                     controller finished initialisation
//   sdram_cmd_* / sdram_addr_x16 /
//   sdram_wr / sdram_wdata        command forwarded from the owning master
//   sdram_resp_valid/sdram_rdata  controller response, routed to the owner
//   sdram_ack                     owner's ack forwarded to the controller
//   err_o                         sticky protocol error, cleared only by reset
module sdram_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic [ADDR_W-1:0] m0_addr_x16,
    output logic              m0_resp_valid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m0_ack,
    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic [ADDR_W-1:0] m1_addr_x16,
    input  logic              m1_wr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_resp_valid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_ack,
    input  logic              sdram_rdy,
    output logic              sdram_cmd_valid,
    input  logic              sdram_cmd_ready,
    output logic [ADDR_W-1:0] sdram_addr_x16,
    output logic              sdram_wr,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic              sdram_resp_valid,
    input  logic [DATA_W-1:0] sdram_rdata,
    output logic              sdram_ack,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD0,
        S_DATA0,
        S_CMD1,
        S_DATA1
    } state_e;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        starve_d        = starve_q;
        m0_cmd_ready    = 1'b0;
        m1_cmd_ready    = 1'b0;
        m0_resp_valid   = 1'b0;
        m1_resp_valid   = 1'b0;
        m0_rdata        = sdram_rdata;
        m1_rdata        = sdram_rdata;
        sdram_cmd_valid = 1'b0;
        sdram_addr_x16  = m0_addr_x16;
        sdram_wr        = 1'b0;
        sdram_wdata     = '0;
        sdram_ack       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sdram_rdy) begin
                    if (m0_cmd_valid && (!m1_cmd_valid || starve_q < LIMIT)) begin
                        state_d = S_CMD0;
                        // Only video grants taken while the CPU waits count toward starvation.
                        if (!m1_cmd_valid)
                            starve_d = '0;
                        else if (starve_q != LIMIT)
                            starve_d = starve_q + 1'b1;
                    end else if (m1_cmd_valid) begin
                        state_d  = S_CMD1;
                        starve_d = '0;
                    end
                end
            end
            S_CMD0: begin
                sdram_cmd_valid = m0_cmd_valid;
                m0_cmd_ready    = sdram_cmd_ready;
                if (!m0_cmd_valid)
                    state_d = S_IDLE;
                else if (sdram_cmd_ready)
                    state_d = S_DATA0;
            end
            S_DATA0: begin
                m0_resp_valid = sdram_resp_valid;
                sdram_ack     = m0_ack;
                if (m0_ack)
                    state_d = S_IDLE;
            end
            S_CMD1: begin
                sdram_cmd_valid = m1_cmd_valid;
                m1_cmd_ready    = sdram_cmd_ready;
                sdram_addr_x16  = m1_addr_x16;
                sdram_wr        = m1_wr;
                sdram_wdata     = m1_wdata;
                if (!m1_cmd_valid)
                    state_d = S_IDLE;
                else if (sdram_cmd_ready)
                    state_d = S_DATA1;
            end
            S_DATA1: begin
                m1_resp_valid = sdram_resp_valid;
                sdram_ack     = m1_ack;
                if (m1_ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Error sources: response outside a data phase, ack from a non-owner,
    // or the owner's ack coinciding with a response word.
    always_comb begin
        err_d = err_q;
        if (sdram_resp_valid && (state_q == S_IDLE || state_q == S_CMD0 || state_q == S_CMD1))
            err_d = 1'b1;
        if (m0_ack && state_q != S_DATA0)
            err_d = 1'b1;
        if (m1_ack && state_q != S_DATA1)
            err_d = 1'b1;
        if (sdram_resp_valid && ((state_q == S_DATA0 && m0_ack) || (state_q == S_DATA1 && m1_ack)))
            err_d = 1'b1;
    end

    assign err_o = err_q;

endmodule
